// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode, sub-op and FSM encodings for the HI/LO multiply/divide unit.
// Op 7 plus op_ext selects the MADD family, present only with MDU_MADD_EN.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_MACC  = 3'd7
    } mdu_op_e;

    // op_ext for OP_MACC: bit 0 = unsigned, bit 1 = subtract
    typedef enum logic [1:0] {
        MX_MADD  = 2'd0,
        MX_MADDU = 2'd1,
        MX_MSUB  = 2'd2,
        MX_MSUBU = 2'd3
    } mdu_macc_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } mdu_state_e;

    // The most-negative XLEN value is the top XLEN bits of this constant.
    localparam logic [63:0] MDU_MOST_NEG = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/mdu_hilo_div_iter.sv
// mdu_div_iter: restoring divider datapath, one quotient bit per cycle.
// The first iteration runs on the start edge; last flags iteration XLEN-1.
module mdu_div_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            en,
    input  logic [XLEN-1:0] dvd,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem,
    output logic            last
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] q_r;
    logic [XLEN-1:0] r_r;
    logic [XLEN-1:0] d_r;
    logic [CW-1:0]   cnt;

    logic [XLEN-1:0] q_in;
    logic [XLEN-1:0] r_in;
    logic [XLEN-1:0] d_in;
    logic [XLEN:0]   sh;
    logic [XLEN:0]   diff;
    logic            ge;

    always_comb begin
        q_in = q_r;
        r_in = r_r;
        d_in = d_r;
        if (start) begin
            q_in = dvd;
            r_in = '0;
            d_in = dvs;
        end
    end

    // Partial remainder stays below the divisor, so bit XLEN of diff is the sign.
    assign sh   = {r_in, q_in[XLEN-1]};
    assign diff = sh - {1'b0, d_in};
    assign ge   = !diff[XLEN];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r <= '0;
            r_r <= '0;
            d_r <= '0;
            cnt <= '0;
        end else if (start || en) begin
            q_r <= {q_in[XLEN-2:0], ge};
            r_r <= ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
            d_r <= d_in;
            cnt <= start ? CW'(1) : cnt + 1'b1;
        end
    end

    assign quo  = q_r;
    assign rem  = r_r;
    assign last = en && (cnt == CW'(XLEN - 1));

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit owning the HI/LO pair.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU on op 7 with op_ext.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    input  logic [2:0]      op,
`ifdef MDU_MADD_EN
    input  logic [1:0]      op_ext,
`endif
    input  logic [XLEN-1:0] num1,
    input  logic [XLEN-1:0] num2,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int MCW = $clog2(MUL_CYCLES + 1);
    localparam logic [XLEN-1:0] SIGN = MDU_MOST_NEG[63 -: XLEN];

    mdu_state_e state, state_n;

    logic [MCW-1:0]  mcnt, mcnt_n;
    logic [XLEN-1:0] hi_n, lo_n;
    logic            done_n;
    logic            accept;
    logic            lat_mul;
    logic            lat_div;

    logic            is_mul;
    logic            is_div;
    logic            sgn_op;

    logic [XLEN-1:0] ma, mb;
    logic            msg;

    logic            in_idle;
    logic [XLEN-1:0] pa, pb;
    logic            psg;
    logic [2*XLEN-1:0] ea, eb;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] mres;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] dam, dbm;
    logic            dsq, dsr;
    logic            div_start;
    logic            div_en;
    logic            div_last;
    logic [XLEN-1:0] dquo, drem;

`ifdef MDU_MADD_EN
    logic            acc_op;
    logic            acc_sub;
    logic            macc, msub;
    logic            pacc, psub;

    assign acc_op  = op == OP_MACC;
    assign acc_sub = (op_ext == MX_MSUB) || (op_ext == MX_MSUBU);
    assign is_mul  = (op == OP_MULT) || (op == OP_MULTU) || acc_op;
    assign sgn_op  = (op == OP_MULT) || (op == OP_DIV) ||
                     (acc_op && ((op_ext == MX_MADD) || (op_ext == MX_MSUB)));
`else
    assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    assign sgn_op  = (op == OP_MULT) || (op == OP_DIV);
`endif
    assign is_div  = (op == OP_DIV) || (op == OP_DIVU);

    assign busy   = (state != S_IDLE) || done;
    assign ready  = !busy;
    assign accept = op_valid && ready && !flush;

    // Operands come straight from the ports only for a same-edge multiply.
    assign in_idle = state == S_IDLE;
    assign pa      = in_idle ? num1 : ma;
    assign pb      = in_idle ? num2 : mb;
    assign psg     = in_idle ? sgn_op : msg;
    assign ea      = {{XLEN{psg & pa[XLEN-1]}}, pa};
    assign eb      = {{XLEN{psg & pb[XLEN-1]}}, pb};
    assign prod    = ea * eb;

`ifdef MDU_MADD_EN
    assign pacc = in_idle ? acc_op : macc;
    assign psub = in_idle ? acc_sub : msub;

    always_comb begin
        mres = prod;
        if (pacc) begin
            mres = psub ? {hi, lo} - prod : {hi, lo} + prod;
        end
    end
`else
    assign mres = prod;
`endif

    assign a_neg = sgn_op && |(num1 & SIGN);
    assign b_neg = sgn_op && |(num2 & SIGN);
    assign dam   = a_neg ? -num1 : num1;
    assign dbm   = b_neg ? -num2 : num2;
    assign div_en = (state == S_DIV) && !flush;

    mdu_div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk  (clk),
        .reset(reset),
        .start(div_start),
        .en   (div_en),
        .dvd  (dam),
        .dvs  (dbm),
        .quo  (dquo),
        .rem  (drem),
        .last (div_last)
    );

    always_comb begin
        state_n   = state;
        mcnt_n    = mcnt;
        hi_n      = hi;
        lo_n      = lo;
        done_n    = 1'b0;
        div_start = 1'b0;
        lat_mul   = 1'b0;
        lat_div   = 1'b0;
        unique case (state)
            S_IDLE: begin
                unique case (1'b1)
                    accept && (op == OP_MTHI): hi_n = num1;
                    accept && (op == OP_MTLO): lo_n = num1;
                    accept && is_mul: begin
                        lat_mul = 1'b1;
                        if (MUL_CYCLES == 1) begin
                            {hi_n, lo_n} = mres;
                            done_n       = 1'b1;
                        end else begin
                            state_n = S_MUL;
                            mcnt_n  = MCW'(MUL_CYCLES - 1);
                        end
                    end
                    accept && is_div && (num2 == '0): begin
                        hi_n   = num1;
                        lo_n   = '1;
                        done_n = 1'b1;
                    end
                    accept && is_div && (num2 != '0): begin
                        div_start = 1'b1;
                        lat_div   = 1'b1;
                        state_n   = S_DIV;
                    end
                    default: ;
                endcase
            end
            S_MUL: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else if (mcnt == MCW'(1)) begin
                    {hi_n, lo_n} = mres;
                    done_n       = 1'b1;
                    state_n      = S_IDLE;
                end else begin
                    mcnt_n = mcnt - 1'b1;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else if (div_last) begin
                    state_n = S_FIX;
                end
            end
            S_FIX: begin
                state_n = S_IDLE;
                if (!flush) begin
                    hi_n   = dsr ? -drem : drem;
                    lo_n   = dsq ? -dquo : dquo;
                    done_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            mcnt  <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            mcnt  <= mcnt_n;
            hi    <= hi_n;
            lo    <= lo_n;
            done  <= done_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma  <= '0;
            mb  <= '0;
            msg <= 1'b0;
`ifdef MDU_MADD_EN
            macc <= 1'b0;
            msub <= 1'b0;
`endif
            dsq <= 1'b0;
            dsr <= 1'b0;
        end else begin
            if (lat_mul) begin
                ma  <= num1;
                mb  <= num2;
                msg <= sgn_op;
`ifdef MDU_MADD_EN
                macc <= acc_op;
                msub <= acc_sub;
`endif
            end
            if (lat_div) begin
                dsq <= a_neg ^ b_neg;
                dsr <= a_neg;
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scoreboard bench for mdu_hilo against an arithmetic model.
// Define MDU_MADD_EN to also exercise the MADD family.
module tb_mdu_hilo;
    import mdu_pkg::*;

    localparam int MULC = 2;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
`ifdef MDU_MADD_EN
    logic [1:0]  op_ext;
`endif
    logic [31:0] num1, num2;
    logic        flush;
    logic        ready, busy, done;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi, m_lo;
    logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF,
                                  32'h8000_0000, 32'h7FFF_FFFF};

    mdu_hilo #(
        .XLEN(32),
        .MUL_CYCLES(MULC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .op_valid(op_valid),
        .op      (op),
`ifdef MDU_MADD_EN
        .op_ext  (op_ext),
`endif
        .num1    (num1),
        .num2    (num2),
        .flush   (flush),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every done must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", {hi, lo}, 64'hx);
            end else begin
                chk("done_hilo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    function automatic bit mulop(input logic [2:0] o);
        return (o == OP_MULT) || (o == OP_MULTU)
`ifdef MDU_MADD_EN
               || (o == OP_MACC)
`endif
               ;
    endfunction

    function automatic bit divop(input logic [2:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] o,
            input logic [1:0] x, input logic [31:0] a, input logic [31:0] b,
            input logic [63:0] hl);
        logic [63:0] p;
        int ia, ib;
        int unsigned ua, ub;
        ia = a; ib = b; ua = a; ub = b;
        case (o)
            OP_MULT:  return 64'(longint'($signed(a)) * longint'($signed(b)));
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'h0, 32'h8000_0000};
                return {32'(ia % ib), 32'(ia / ib)};
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            OP_MACC: begin
                if (x[0]) p = {32'b0, a} * {32'b0, b};
                else p = 64'(longint'($signed(a)) * longint'($signed(b)));
                return x[1] ? hl - p : hl + p;
            end
            default: return hl;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    task automatic issue(input logic [2:0] o, input logic [1:0] x,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit track);
        logic [63:0] r;
        int w = 0;
        while (!ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!ready) chk("ready_timeout", ready, 1);
        op_valid = 1'b1;
        op = o;
        num1 = a;
        num2 = b;
`ifdef MDU_MADD_EN
        op_ext = x;
`endif
        if (track) begin
            if (o == OP_MTHI) m_hi = a;
            else if (o == OP_MTLO) m_lo = a;
            else if (mulop(o) || divop(o)) begin
                r = ref_result(o, x, a, b, {m_hi, m_lo});
                exp_q.push_back(r);
                {m_hi, m_lo} = r;
            end
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        op = OP_NOP;
    endtask

    task automatic wait_done(output int dc, output int bc);
        dc = 0;
        bc = 0;
        for (int n = 1; n <= 200; n++) begin
            if (busy) bc++;
            if (done && dc == 0) dc = n;
            if (!busy) break;
            @(posedge clk); #1;
        end
        if (busy) chk("busy_timeout", busy, 0);
    endtask

    task automatic settle(input logic [2:0] o, input logic [31:0] b);
        int dc, bc, ed;
        wait_done(dc, bc);
        ed = mulop(o) ? MULC : divop(o) ? ((b == 0) ? 1 : 33) : 0;
        chk("done_latency", dc, ed);
        chk("busy_cycles", bc, ed);
        chk("hilo_model", {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        int dc, bc;
        op_valid = 1'b0;
        op = OP_NOP;
        num1 = '0;
        num2 = '0;
        flush = 1'b0;
`ifdef MDU_MADD_EN
        op_ext = '0;
`endif
        m_hi = '0;
        m_lo = '0;
        reset = 1'b1;
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ready", ready, 1);

        issue(OP_MULT, 0, 32'hFFFF_FFFE, 32'd3, 1);
        settle(OP_MULT, 32'd3);
        chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(OP_MULTU, 0, 32'hFFFF_FFFE, 32'd3, 1);
        settle(OP_MULTU, 32'd3);
        chk("multu_const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

        issue(OP_DIV, 0, 32'hFFFF_FFF9, 32'd2, 1);
        settle(OP_DIV, 32'd2);
        chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(OP_DIVU, 0, 32'd100, 32'd7, 1);
        settle(OP_DIVU, 32'd7);
        chk("divu_const", {hi, lo}, {32'd2, 32'd14});
        issue(OP_DIV, 0, 32'h1234_5678, 32'd0, 1);
        settle(OP_DIV, 32'd0);
        chk("div0_const", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        issue(OP_DIV, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        settle(OP_DIV, 32'hFFFF_FFFF);
        chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        // Flush a divide at iteration 10; a new multiply follows at once.
        issue(OP_DIV, 0, 32'd1000, 32'd7, 0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_ready", ready, 1);
        chk("flush_hilo", {hi, lo}, {m_hi, m_lo});
        issue(OP_MULT, 0, 32'd6, 32'd7, 1);
        settle(OP_MULT, 32'd7);

        issue(OP_MTHI, 0, 32'hA5A5_A5A5, 32'd0, 1);
        issue(OP_MTLO, 0, 32'h5A5A_5A5A, 32'd0, 1);
        chk("mthi_mtlo", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);
        chk("mt_no_busy", busy, 0);

        op_valid = 1'b1;
        op = OP_MTHI;
        num1 = 32'h1111_1111;
        flush = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        flush = 1'b0;
        chk("flush_beats_op", hi, m_hi);

        issue(OP_DIV, 0, 32'hFFFF_FF00, 32'd9, 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("busy_not_ready", ready, 0);
        op_valid = 1'b1;
        op = OP_MTHI;
        num1 = 32'hDEAD_BEEF;
        repeat (2) begin
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        op = OP_NOP;
        wait_done(dc, bc);
        chk("ignored_during_busy", {hi, lo}, {m_hi, m_lo});

        for (int i = 0; i < 40; i++) begin
            logic [2:0] o;
            logic [1:0] x;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 7));
            x = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            issue(o, x, a, b, 1);
            settle(o, b);
        end

`ifdef MDU_MADD_EN
        issue(OP_MTHI, 0, 32'd0, 32'd0, 1);
        issue(OP_MTLO, 0, 32'd1, 32'd0, 1);
        issue(OP_MACC, MX_MADD, 32'd2, 32'd3, 1);
        settle(OP_MACC, 32'd3);
        chk("madd_const", {hi, lo}, 64'd7);
`endif

        // Asynchronous reset in the middle of a multiply.
        issue(OP_MULT, 0, 32'h1234, 32'h5678, 0);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_hilo", {hi, lo}, 64'h0);
        chk("async_rst_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("post_rst_hilo", {hi, lo}, {m_hi, m_lo});
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
